// File: rtl/func_bist_pkg.sv
// Shared types and helpers for the Func self-test engine and its LFSR pattern source.
// Holds the controller state encoding, the maximal-length tap table and the golden Func equation.
package func_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } bist_state_t;

  localparam int LFSR_W_MIN = 4;
  localparam int LFSR_W_MAX = 16;
  localparam int VEC_W      = 4;
  localparam int CNT_W      = 16;

  // Tap masks for a left-shifting Fibonacci LFSR: bit i set means register bit i feeds the XOR.
  function automatic logic [15:0] lfsr_taps(input int w);
    logic [15:0] m;
    case (w)
      4:       m = 16'h000C;
      5:       m = 16'h0014;
      6:       m = 16'h0030;
      7:       m = 16'h0060;
      8:       m = 16'h00B8;
      9:       m = 16'h0110;
      10:      m = 16'h0240;
      11:      m = 16'h0500;
      12:      m = 16'h0829;
      13:      m = 16'h100D;
      14:      m = 16'h2015;
      15:      m = 16'h6000;
      16:      m = 16'hD008;
      default: m = 16'h00B8;
    endcase
    return m;
  endfunction

  function automatic logic func_golden(input logic a, input logic b, input logic c);
    return (a & b) | c;
  endfunction

endpackage

// File: rtl/func_bist_ctrl_if.sv
// Bundle of the self-test engine's control, status and Func-facing signals.
// The controller takes the master view; whatever drives start and hosts Func takes the slave view.
interface func_bist_ctrl_if;
  logic        start;
  logic        dut_out;
  logic        dut_out_bar;
  logic        A;
  logic        B;
  logic        C;
  logic        Sel;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_cnt;
  logic [15:0] vec_cnt;
  logic [3:0]  fail_vec;

  modport master (
    input  start, dut_out, dut_out_bar,
    output A, B, C, Sel, busy, done, pass, err_cnt, vec_cnt, fail_vec
  );

  modport slave (
    output start, dut_out, dut_out_bar,
    input  A, B, C, Sel, busy, done, pass, err_cnt, vec_cnt, fail_vec
  );
endinterface

// File: rtl/func_bist_ctrl_lfsr_gen.sv
// Fibonacci LFSR pattern source, shifting left with feedback into bit 0.
// A zero seed is replaced by 1 so the register can never lock up in the all-zero state.
module lfsr_gen
  import func_bist_pkg::*;
#(
  parameter int LFSR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  output logic [LFSR_W-1:0] q
);

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

  logic [LFSR_W-1:0] seed_eff;
  logic              fb;

  assign seed_eff = (seed == '0) ? LFSR_W'(1) : seed;
  assign fb       = ^(q & TAPS);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      q <= seed_eff;
    end else if (step) begin
      q <= {q[LFSR_W-2:0], fb};
    end
  end

endmodule

// File: rtl/func_bist_ctrl.sv
// On-board self-test engine for the combinational Func block: drives LFSR vectors,
// checks each response one cycle later against the golden equation and tallies mismatches.
module func_bist_ctrl
  import func_bist_pkg::*;
#(
  parameter int unsigned     N_VECTORS   = 99,
  parameter int              LFSR_W      = 8,
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(8'hA5),
  parameter bit              STOP_ON_ERR = 1'b1,
  parameter bit              CHECK_SEL1  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  func_bist_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] N_LIM = CNT_W'(N_VECTORS);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  bist_state_t       state_q;
  bist_state_t       state_d;
  logic              start_ok;
  logic              lfsr_load;
  logic              lfsr_step;
  logic [LFSR_W-1:0] lfsr_q;
  logic              lfsr_unused;

  logic [VEC_W-1:0]  vec_q;
  logic [CNT_W-1:0]  err_cnt_q;
  logic [CNT_W-1:0]  vec_cnt_q;
  logic [VEC_W-1:0]  fail_vec_q;

  logic              exp_out;
  logic              compl_bad;
  logic              func_bad;
  logic              mismatch;
  logic              last_vec;

  lfsr_gen #(
    .LFSR_W (LFSR_W)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .seed (SEED),
    .step (lfsr_step),
    .q    (lfsr_q)
  );

  // Only the low four LFSR bits form a vector; the upper bits just lengthen the sequence.
  assign lfsr_unused = ^(lfsr_q >> VEC_W);

  assign start_ok = bus.start && ((state_q == IDLE) || (state_q == DONE));

  // vec_q is {Sel,C,B,A}; Func has settled by SAMPLE because the inputs were registered in DRIVE.
  always_comb begin
    exp_out   = func_golden(vec_q[0], vec_q[1], vec_q[2]);
    compl_bad = (bus.dut_out_bar != ~bus.dut_out);
    func_bad  = (bus.dut_out != exp_out) && (!vec_q[3] || CHECK_SEL1);
    mismatch  = compl_bad || func_bad;
    last_vec  = ((vec_cnt_q + CNT_W'(1)) == N_LIM);
  end

  always_comb begin
    state_d   = state_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          state_d   = DRIVE;
          lfsr_load = 1'b1;
        end
      end
      DRIVE: begin
        state_d = SAMPLE;
      end
      SAMPLE: begin
        lfsr_step = 1'b1;
        if (last_vec || (mismatch && STOP_ON_ERR)) begin
          state_d = DONE;
        end else begin
          state_d = DRIVE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // p0: vector launch in DRIVE; p1: response check and bookkeeping in SAMPLE
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q      <= '0;
      err_cnt_q  <= '0;
      vec_cnt_q  <= '0;
      fail_vec_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_ok) begin
            err_cnt_q  <= '0;
            vec_cnt_q  <= '0;
            fail_vec_q <= '0;
          end
        end
        DRIVE: begin
          vec_q <= lfsr_q[VEC_W-1:0];
        end
        SAMPLE: begin
          vec_cnt_q <= vec_cnt_q + CNT_W'(1);
          if (mismatch) begin
            err_cnt_q <= sat_inc(err_cnt_q);
            if (err_cnt_q == '0) begin
              fail_vec_q <= vec_q;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.A        = vec_q[0];
  assign bus.B        = vec_q[1];
  assign bus.C        = vec_q[2];
  assign bus.Sel      = vec_q[3];
  assign bus.busy     = (state_q == DRIVE) || (state_q == SAMPLE);
  assign bus.done     = (state_q == DONE);
  assign bus.pass     = (state_q == DONE) && (err_cnt_q == '0);
  assign bus.err_cnt  = err_cnt_q;
  assign bus.vec_cnt  = vec_cnt_q;
  assign bus.fail_vec = fail_vec_q;

endmodule

// File: tb/tb_func_bist_ctrl.sv
// Scoreboard bench for func_bist_ctrl: three engines with different parameters, each beside a
// behavioural Func model (golden or faulty); run results are queued at start and checked at done.
module tb_func_bist_ctrl;

  typedef struct {
    logic [15:0] err;
    logic [15:0] vec;
    logic [3:0]  fv;
    logic        pass;
    int          lat;
    int          t0;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start_v;
  int         f0;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;

  exp_t       exp0[$];
  exp_t       exp1[$];
  exp_t       exp2[$];
  logic [3:0] vexp2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  func_bist_ctrl_if bus0();
  func_bist_ctrl_if bus1();
  func_bist_ctrl_if bus2();

  logic gold0, gold1, gold2;
  assign gold0 = (bus0.A & bus0.B) | bus0.C;
  assign gold1 = (bus1.A & bus1.B) | bus1.C;
  assign gold2 = (bus2.A & bus2.B) | bus2.C;

  // u0: golden or out stuck at 0; u1: Out_bar shorted to out; u2: golden
  assign bus0.start       = start_v[0];
  assign bus0.dut_out     = (f0 == 1) ? 1'b0 : gold0;
  assign bus0.dut_out_bar = (f0 == 1) ? 1'b1 : ~gold0;
  assign bus1.start       = start_v[1];
  assign bus1.dut_out     = gold1;
  assign bus1.dut_out_bar = gold1;
  assign bus2.start       = start_v[2];
  assign bus2.dut_out     = gold2;
  assign bus2.dut_out_bar = ~gold2;

  func_bist_ctrl u0 (.clk(clk), .rst(rst), .bus(bus0));
  func_bist_ctrl #(.N_VECTORS(20), .STOP_ON_ERR(1'b0)) u1 (.clk(clk), .rst(rst), .bus(bus1));
  func_bist_ctrl #(.N_VECTORS(255), .SEED(8'h00)) u2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    n_vec++;
    n_err++;
    $display("FAIL %s: %s", name, msg);
  endtask

  task automatic done_check(input string tag, input exp_t e, input logic [15:0] err,
                            input logic [15:0] vec, input logic [3:0] fv, input logic pass,
                            input int now);
    chk({tag, " err_cnt"}, 32'(err), 32'(e.err));
    chk({tag, " vec_cnt"}, 32'(vec), 32'(e.vec));
    chk({tag, " fail_vec"}, 32'(fv), 32'(e.fv));
    chk({tag, " pass"}, 32'(pass), 32'(e.pass));
    chk({tag, " latency"}, 32'(now - e.t0), 32'(e.lat));
  endtask

  // Done monitor: pops the expected run result on each rising done.
  logic [2:0] done_prev = 3'b000;
  exp_t       e_mon;
  always @(negedge clk) begin
    if (bus0.done && !done_prev[0]) begin
      if (exp0.size() == 0) fail_now("u0 done", "done with no run outstanding");
      else begin
        e_mon = exp0.pop_front();
        done_check("u0", e_mon, bus0.err_cnt, bus0.vec_cnt, bus0.fail_vec, bus0.pass, cyc);
      end
    end
    if (bus1.done && !done_prev[1]) begin
      if (exp1.size() == 0) fail_now("u1 done", "done with no run outstanding");
      else begin
        e_mon = exp1.pop_front();
        done_check("u1", e_mon, bus1.err_cnt, bus1.vec_cnt, bus1.fail_vec, bus1.pass, cyc);
      end
    end
    if (bus2.done && !done_prev[2]) begin
      if (exp2.size() == 0) fail_now("u2 done", "done with no run outstanding");
      else begin
        e_mon = exp2.pop_front();
        done_check("u2", e_mon, bus2.err_cnt, bus2.vec_cnt, bus2.fail_vec, bus2.pass, cyc);
      end
    end
    done_prev = {bus2.done, bus1.done, bus0.done};
  end

  // Vector monitor for u2: the applied vector is visible in every second busy cycle (SAMPLE).
  logic       ph2 = 1'b0;
  logic [3:0] v_mon;
  always @(negedge clk) begin
    if (!bus2.busy) ph2 = 1'b0;
    else begin
      if (ph2) begin
        if (vexp2.size() == 0) fail_now("u2 vector", "vector with none expected");
        else begin
          v_mon = vexp2.pop_front();
          chk("u2 vector", 32'({bus2.Sel, bus2.C, bus2.B, bus2.A}), 32'(v_mon));
        end
      end
      ph2 = ~ph2;
    end
  end

  task automatic run(input int which, input exp_t e);
    e.t0 = cyc + 1;
    case (which)
      0: exp0.push_back(e);
      1: exp1.push_back(e);
      default: exp2.push_back(e);
    endcase
    start_v[which] = 1'b1;
    @(negedge clk);
    start_v[which] = 1'b0;
  endtask

  task automatic wait_done(input int which, input int limit);
    logic [2:0] d;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      d = {bus2.done, bus1.done, bus0.done};
      if (d[which]) begin
        @(negedge clk);
        return;
      end
    end
    fail_now("wait_done", $sformatf("u%0d done not seen within %0d cycles", which, limit));
  endtask

  task automatic wait_vec0(input logic [15:0] n, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (bus0.vec_cnt == n) return;
      @(negedge clk);
    end
    fail_now("wait_vec", $sformatf("u0 vec_cnt never reached %0d", n));
  endtask

  task automatic chk_zero0(input string pfx);
    chk({pfx, " A"}, 32'(bus0.A), 0);
    chk({pfx, " B"}, 32'(bus0.B), 0);
    chk({pfx, " C"}, 32'(bus0.C), 0);
    chk({pfx, " Sel"}, 32'(bus0.Sel), 0);
    chk({pfx, " busy"}, 32'(bus0.busy), 0);
    chk({pfx, " done"}, 32'(bus0.done), 0);
    chk({pfx, " pass"}, 32'(bus0.pass), 0);
    chk({pfx, " err_cnt"}, 32'(bus0.err_cnt), 0);
    chk({pfx, " vec_cnt"}, 32'(bus0.vec_cnt), 0);
    chk({pfx, " fail_vec"}, 32'(bus0.fail_vec), 0);
  endtask

  initial begin
    repeat (30000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  localparam exp_t GOLD99  = '{16'd0, 16'd99, 4'h0, 1'b1, 198, 0};
  localparam exp_t STUCK0  = '{16'd1, 16'd1, 4'h5, 1'b0, 2, 0};
  localparam exp_t SHORT20 = '{16'd20, 16'd20, 4'h5, 1'b0, 40, 0};
  localparam exp_t GOLD255 = '{16'd0, 16'd255, 4'h0, 1'b1, 510, 0};

  initial begin
    logic [7:0] q;
    rst     = 1'b1;
    start_v = 3'b000;
    f0      = 0;
    repeat (2) @(negedge clk);
    chk_zero0("reset");
    rst = 1'b0;

    // Out_bar shorted to out, all 20 vectors run, every one fails
    run(1, SHORT20);
    wait_done(1, 100);

    // SEED=0 behaves as seed 1; first vector is 4'b0001, full 255-step period follows
    q = 8'h01;
    for (int i = 0; i < 255; i++) begin
      vexp2.push_back(q[3:0]);
      q = {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end
    run(2, GOLD255);
    wait_done(2, 700);

    // Golden Func, default parameters
    run(0, GOLD99);
    wait_done(0, 400);

    // out stuck at 0: first vector 4'b0101 expects 1, run stops there
    f0 = 1;
    run(0, STUCK0);
    wait_done(0, 50);

    // Restart from DONE clears counters; a start while busy is ignored
    f0 = 0;
    run(0, GOLD99);
    wait_vec0(16'd30, 200);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0, 400);

    // Reset mid-run abandons the run with no done
    run(0, GOLD99);
    wait_vec0(16'd40, 200);
    rst = 1'b1;
    @(negedge clk);
    chk_zero0("midrun reset");
    exp0.delete();
    rst = 1'b0;
    run(0, GOLD99);
    wait_done(0, 400);

    repeat (3) @(negedge clk);
    chk("u0 runs outstanding", 32'(exp0.size()), 0);
    chk("u1 runs outstanding", 32'(exp1.size()), 0);
    chk("u2 runs outstanding", 32'(exp2.size()), 0);
    chk("u2 vectors outstanding", 32'(vexp2.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
